// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding and nibble width
package nibble_serial_adder_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/nibble_serial_adder_nibble_add.sv
// nibble_add: combinational 4-bit adder with carry-in and carry-out
module nibble_add
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: wide unsigned adder computed one nibble per clock through a single nibble adder
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NIBBLE_W*NIBBLES-1:0] A,
  input  logic [NIBBLE_W*NIBBLES-1:0] B,
  input  logic                      c_in,
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      c_out
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_n;
  logic [W-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic carry, cy, last, accept;
  logic [NIBBLE_W-1:0] s;
  nibble_add u_add (
    .a (a_q[idx*NIBBLE_W +: NIBBLE_W]),
    .b (b_q[idx*NIBBLE_W +: NIBBLE_W]),
    .ci(carry),
    .s (s),
    .co(cy)
  );
  assign last   = idx == IW'(NIBBLES - 1);
  assign accept = start && state != ST_RUN;
  assign busy   = state == ST_RUN;
  assign done   = state == ST_DONE;
  // IDLE and DONE share the same exit: a start launches a new run
  always_comb begin
    state_n = state == ST_RUN ? (last ? ST_DONE : ST_RUN) : (start ? ST_RUN : ST_IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        carry <= c_in;
        idx   <= '0;
        sum   <= '0;
        c_out <= 1'b0;
      end else if (state == ST_RUN) begin
        sum[idx*NIBBLE_W +: NIBBLE_W] <= s;
        carry <= cy;
        idx   <= last ? '0 : idx + 1'b1;
        if (last) c_out <= cy;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized self-checking bench for 4-nibble and 1-nibble configurations
module tb_nibble_serial_adder;
  logic clk = 0, rst = 1;
  logic start4 = 0, ci4 = 0, busy4, done4, co4;
  logic [15:0] a4 = 0, b4 = 0, sum4;
  logic start1 = 0, ci1 = 0, busy1, done1, co1;
  logic [3:0] a1 = 0, b1 = 0, sum1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .c_in(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(co4)
  );
  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1)
  );

  function automatic logic [16:0] ref4(input logic [15:0] a, input logic [15:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + 17'(ci);
  endfunction

  function automatic logic [4:0] ref1(input logic [3:0] a, input logic [3:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + 5'(ci);
  endfunction

  // Launches one addition and reports what was observed; lat counts edges from the accepting edge
  task automatic do_add(input int sel, input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output logic [15:0] s, output logic co, output int lat, output int nbusy,
                        output logic [16:0] s_acc);
    @(negedge clk);
    if (sel == 1) begin a1 = a[3:0]; b1 = b[3:0]; ci1 = ci; start1 = 1; end
    else begin a4 = a; b4 = b; ci4 = ci; start4 = 1; end
    @(negedge clk);
    start1 = 0; start4 = 0;
    a4 = 16'($urandom); b4 = 16'($urandom); ci4 = 1'($urandom);
    a1 = 4'($urandom); b1 = 4'($urandom); ci1 = 1'($urandom);
    s_acc = sel == 1 ? {12'b0, co1, sum1} : {co4, sum4};
    lat = 1; nbusy = 0;
    while (!(sel == 1 ? done1 : done4) && lat < 40) begin
      if (sel == 1 ? busy1 : busy4) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) lat = -1;
    s = sel == 1 ? {12'b0, sum1} : sum4;
    co = sel == 1 ? co1 : co4;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy4, done4, co4, sum4} !== 19'b0) begin
      failures++;
      $display("FAIL reset4 got busy=%b done=%b c_out=%b sum=%h want all 0", busy4, done4, co4, sum4);
    end
    checks++;
    if ({busy1, done1, co1, sum1} !== 7'b0) begin
      failures++;
      $display("FAIL reset1 got busy=%b done=%b c_out=%b sum=%h want all 0", busy1, done1, co1, sum1);
    end
    rst = 0;
  endtask

  task automatic test_directed;
    logic [15:0] ta[4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h0000};
    logic [15:0] tb[4] = '{16'h4321, 16'h0001, 16'hFFFF, 16'h0000};
    logic        tc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] s; logic co; int lat, nb; logic [16:0] sa, e;
    for (int i = 0; i < 4; i++) begin
      e = ref4(ta[i], tb[i], tc[i]);
      do_add(0, ta[i], tb[i], tc[i], s, co, lat, nb, sa);
      checks++;
      if ({co, s} !== e) begin
        failures++;
        $display("FAIL directed%0d sum got %b_%h want %b_%h", i, co, s, e[16], e[15:0]);
      end
      checks++;
      if (lat != 5 || nb != 4) begin
        failures++;
        $display("FAIL directed%0d timing got lat=%0d busy=%0d want lat=5 busy=4", i, lat, nb);
      end
      checks++;
      if (sa !== 17'b0) begin
        failures++;
        $display("FAIL directed%0d clear_on_start got %h want 0", i, sa);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int dones = 0, cyc = 0, done_cyc = -1;
    logic [15:0] s = 0;
    @(negedge clk);
    a4 = 16'h0A0B; b4 = 16'h0102; ci4 = 0; start4 = 1;
    @(negedge clk); cyc = 1; start4 = 0;
    @(negedge clk); cyc = 2; a4 = 16'hFFFF; b4 = 16'hFFFF; ci4 = 1; start4 = 1;
    @(negedge clk); cyc = 3; start4 = 0;
    while (cyc < 15) begin
      if (done4) begin dones++; s = sum4; done_cyc = cyc; end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (dones != 1 || done_cyc != 5) begin
      failures++;
      $display("FAIL busy_start pulses got %0d at %0d want 1 at 5", dones, done_cyc);
    end
    checks++;
    if (s !== 16'h0B0D) begin
      failures++;
      $display("FAIL busy_start sum got %h want 0b0d", s);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones = 0;
    logic [15:0] s; logic co; int lat, nb; logic [16:0] sa, e;
    @(negedge clk);
    a4 = 16'h8888; b4 = 16'h8888; ci4 = 1; start4 = 1;
    @(negedge clk); start4 = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    checks++;
    if ({busy4, done4, co4, sum4} !== 19'b0) begin
      failures++;
      $display("FAIL mid_rst got busy=%b done=%b c_out=%b sum=%h want all 0", busy4, done4, co4, sum4);
    end
    repeat (8) begin
      if (done4) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL mid_rst_pulse got %0d done pulses want 0", dones);
    end
    rst = 1; start4 = 1;
    @(negedge clk); rst = 0; start4 = 0;
    checks++;
    if (busy4 !== 1'b0) begin
      failures++;
      $display("FAIL rst_wins got busy=%b want 0", busy4);
    end
    e = ref4(16'h7F3C, 16'h80C4, 1'b0);
    do_add(0, 16'h7F3C, 16'h80C4, 1'b0, s, co, lat, nb, sa);
    checks++;
    if ({co, s} !== e || lat != 5) begin
      failures++;
      $display("FAIL post_rst got %b_%h lat=%0d want %b_%h lat=5", co, s, lat, e[16], e[15:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] la[3], lb[3]; logic lc[3];
    logic [16:0] e;
    int k = 0, cyc = 0, last = 0;
    for (int i = 0; i < 3; i++) begin la[i] = 16'($urandom); lb[i] = 16'($urandom); lc[i] = 1'($urandom); end
    la[1] = 16'hFFFF; lb[1] = 16'h0001; lc[1] = 1'b0;
    @(negedge clk);
    a4 = la[0]; b4 = lb[0]; ci4 = lc[0]; start4 = 1;
    @(negedge clk); cyc = 1;
    while (k < 3 && cyc < 60) begin
      if (done4) begin
        e = ref4(la[k], lb[k], lc[k]);
        checks++;
        if ({co4, sum4} !== e || cyc - last != 5) begin
          failures++;
          $display("FAIL b2b%0d got %b_%h gap=%0d want %b_%h gap=5", k, co4, sum4, cyc - last, e[16], e[15:0]);
        end
        last = cyc;
        k++;
        if (k < 3) begin a4 = la[k]; b4 = lb[k]; ci4 = lc[k]; end
        else start4 = 0;
      end else begin
        a4 = 16'($urandom); b4 = 16'($urandom); ci4 = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start4 = 0;
    checks++;
    if (k != 3) begin
      failures++;
      $display("FAIL b2b_timeout got %0d results want 3", k);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b, s; logic c, co; int lat, nb; logic [16:0] sa, e;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      e = ref4(a, b, c);
      do_add(0, a, b, c, s, co, lat, nb, sa);
      checks++;
      if ({co, s} !== e || lat != 5) begin
        failures++;
        $display("FAIL rand%0d %h+%h+%b got %b_%h lat=%0d want %b_%h lat=5", i, a, b, c, co, s, lat, e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_nibbles1;
    logic [15:0] a, b, s; logic c, co; int lat, nb; logic [16:0] sa; logic [4:0] e;
    for (int i = 0; i < 8; i++) begin
      a = i == 0 ? 16'hF : 16'($urandom_range(0, 15));
      b = i == 0 ? 16'h1 : 16'($urandom_range(0, 15));
      c = i == 0 ? 1'b0 : 1'($urandom);
      e = ref1(a[3:0], b[3:0], c);
      do_add(1, a, b, c, s, co, lat, nb, sa);
      checks++;
      if ({co, s[3:0]} !== e || lat != 2 || nb != 1) begin
        failures++;
        $display("FAIL n1_%0d %h+%h+%b got %b_%h lat=%0d busy=%0d want %b_%h lat=2 busy=1",
                 i, a[3:0], b[3:0], c, co, s[3:0], lat, nb, e[4], e[3:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_start_while_busy;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
    test_nibbles1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
